// File: rtl/decoder_3x8_hold_pkg.sv
// Shared definitions for the 3-to-8 hold decoder.
// The package provides:
//   - code and output widths,
//   - the state encoding,
//   - a one-hot helper that encoder benches can also use.
package decoder_3x8_hold_pkg;

  localparam int unsigned CODE_W  = 3;
  localparam int unsigned OUT_W   = 1 << CODE_W;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // One-hot line for a binary code.
  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    return OUT_W'(1) << code;
  endfunction

endpackage

// File: rtl/decoder_3x8_hold_hold_timer.sv
// Down-counting hold timer.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   load         strobe; count takes load_val on this cycle
//   load_val     reload value
//   zero         high while count is zero
// The count stops at zero rather than wrapping.
module hold_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/decoder_3x8_hold.sv
// Registered 3-to-8 one-hot decoder with a hold time.
// An accepted code drives its one-hot line for HOLD_CYCLES clocks.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   in_valid     producer presents in_code
//   in_ready     a code can be taken this cycle
//   in_code      code to decode
//   in_en        0 means the code is accepted but data stays zero
//   data         registered one-hot output
//   out_valid    data holds a live decode
//   busy         FSM is in HOLD
//   accept_cnt   count of accepted codes; wraps
module decoder_3x8_hold
  import decoder_3x8_hold_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_en,
  output logic [OUT_W-1:0]  data,
  output logic              out_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  accept_cnt
);

  state_t state;
  logic   timer_zero;
  logic   accept;

  // Ready depends only on the timer, so a code can be taken in the last hold cycle.
  // The timer is also zero in IDLE, so IDLE is always ready.
  assign in_ready = timer_zero;
  assign accept   = in_valid & in_ready;
  assign busy     = (state == ST_HOLD);

  hold_timer #(
    .W (TIMER_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (TIMER_W'(HOLD_CYCLES - 1)),
    .zero     (timer_zero)
  );

  // FSM, output registers and accept counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      data       <= '0;
      out_valid  <= 1'b0;
      accept_cnt <= '0;
    end else begin
      if (accept) begin
        accept_cnt <= accept_cnt + CNT_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data      <= in_en ? onehot(in_code) : '0;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (accept) begin
            // A reload in the last hold cycle keeps the line busy with no zero gap.
            data      <= in_en ? onehot(in_code) : '0;
            out_valid <= 1'b1;
          end else if (timer_zero) begin
            data      <= '0;
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
